// File: rtl/uart_tx_ctrl_pkg.sv
// Shared definitions for the UART TX controller: bus address defaults,
// status-word bit positions, FSM state encodings and the status packer.
package uart_tx_ctrl_pkg;

  localparam logic [15:0] DEF_STATUS_ADDR = 16'h0800;
  localparam logic [15:0] DEF_DATA_ADDR   = 16'h0801;

  localparam int ST_BIT_NOT_FULL  = 0;
  localparam int ST_BIT_EMPTY     = 1;
  localparam int ST_BIT_BUSY      = 2;
  localparam int ST_BIT_OVERFLOW  = 3;
  localparam int ST_BIT_COUNT_LSB = 8;
  localparam int ST_COUNT_W       = 5;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_LOW  = 2'd2;
  localparam logic [1:0] ST_WAIT_HIGH = 2'd3;

  // Fourth consecutive idle-high cycle in WAIT_LOW means the start was lost.
  localparam logic [1:0] LOST_START_LAST = 2'd3;

  function automatic logic [15:0] pack_status(
    input logic                  not_full,
    input logic                  empty,
    input logic                  busy,
    input logic                  overflow,
    input logic [ST_COUNT_W-1:0] count
  );
    logic [15:0] word;
    word                                 = 16'h0000;
    word[ST_BIT_NOT_FULL]                = not_full;
    word[ST_BIT_EMPTY]                   = empty;
    word[ST_BIT_BUSY]                    = busy;
    word[ST_BIT_OVERFLOW]                = overflow;
    word[ST_BIT_COUNT_LSB +: ST_COUNT_W] = count;
    return word;
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// Synchronous byte FIFO with occupancy count; a push on full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = AW + 1
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             full_s;
  logic             empty_s;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == CW'(0));
  assign pop_ok_s  = pop && !empty_s;
  assign push_ok_s = push && (!full_s || pop_ok_s);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= wdata;
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_s;
  assign empty = empty_s;
  assign count = count_r;

endmodule

// File: rtl/uart_tx_ctrl.sv
// CPU-facing UART transmit controller: bus decode, sticky overflow,
// registered status read-back and the start/handshake FSM.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] STATUS_ADDR = DEF_STATUS_ADDR,
  parameter logic [15:0] DATA_ADDR   = DEF_DATA_ADDR
) (
  input  logic        clock,
  input  logic        rst,
  input  logic [15:0] bus_addr,
  input  logic [15:0] bus_wdata,
  input  logic        bus_we,
  output logic [15:0] rd_data,
  output logic        rd_hit,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  input  logic        tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic [1:0]    lost_cnt_r;
  logic [1:0]    lost_cnt_nxt_s;
  logic          pop_s;
  logic          push_s;
  logic          data_wr_s;
  logic          status_wr_s;
  logic          full_s;
  logic          empty_s;
  logic [7:0]    head_s;
  logic [CW-1:0] count_s;
  logic          overflow_r;
  logic          tx_start_r;
  logic [7:0]    tx_data_r;
  logic [15:0]   status_s;
  logic [15:0]   rd_data_r;
  logic          rd_hit_r;

  assign data_wr_s   = bus_we && (bus_addr == DATA_ADDR);
  assign status_wr_s = bus_we && (bus_addr == STATUS_ADDR);
  assign push_s      = data_wr_s && (!full_s || pop_s);

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clock (clock),
    .rst   (rst),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (bus_wdata[7:0]),
    .rdata (head_s),
    .full  (full_s),
    .empty (empty_s),
    .count (count_s)
  );

  // Next-state and pop decision for the transmit handshake.
  always_comb begin
    state_nxt_s    = state_r;
    lost_cnt_nxt_s = lost_cnt_r;
    pop_s          = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s && tx_ready) begin
          pop_s       = 1'b1;
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        state_nxt_s    = ST_WAIT_LOW;
        lost_cnt_nxt_s = 2'd0;
      end
      ST_WAIT_LOW: begin
        if (!tx_ready) begin
          state_nxt_s = ST_WAIT_HIGH;
        end else if (lost_cnt_r == LOST_START_LAST) begin
          state_nxt_s = ST_IDLE;
        end else begin
          lost_cnt_nxt_s = lost_cnt_r + 2'd1;
        end
      end
      ST_WAIT_HIGH: begin
        if (tx_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WAIT_HIGH;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // tx_start is registered from the pop so it is high exactly while in START.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      lost_cnt_r <= 2'd0;
      tx_start_r <= 1'b0;
      tx_data_r  <= 8'h00;
    end else begin
      state_r    <= state_nxt_s;
      lost_cnt_r <= lost_cnt_nxt_s;
      tx_start_r <= pop_s;
      if (pop_s) begin
        tx_data_r <= head_s;
      end else begin
        tx_data_r <= tx_data_r;
      end
    end
  end

  // Sticky overflow: set by a dropped data write, cleared by writing bit 3 of status.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (data_wr_s && full_s && !pop_s) begin
      overflow_r <= 1'b1;
    end else if (status_wr_s && bus_wdata[ST_BIT_OVERFLOW]) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign status_s = pack_status(!full_s, empty_s, (state_r != ST_IDLE), overflow_r,
                                ST_COUNT_W'(count_s));

  // Read port behaves like data memory: address this cycle, data next cycle.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      rd_hit_r  <= 1'b0;
      rd_data_r <= 16'h0000;
    end else begin
      rd_hit_r <= (bus_addr == STATUS_ADDR);
      if (bus_addr == STATUS_ADDR) begin
        rd_data_r <= status_s;
      end else begin
        rd_data_r <= 16'h0000;
      end
    end
  end

  assign tx_start = tx_start_r;
  assign tx_data  = tx_data_r;
  assign rd_data  = rd_data_r;
  assign rd_hit   = rd_hit_r;

endmodule
